// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and
// load-use / branch hazard control for a 5-stage RISC-V pipeline.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   *_d                        decode-stage fields captured into EX
//   alu_result_m, rd_m, ...    MEM-stage forwarding source
//   result_w, rd_w, ...        WB-stage forwarding source
//   pcsrc_e                    taken branch/jump resolved in EX
//   src_a_e, src_b_e           forwarded ALU operands
//   write_data_e               forwarded rs2 data for stores
//   *_e                        registered EX-stage fields
//   stall_f, stall_d, flush_d  hazard controls to fetch/decode
module id_ex_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] rd1_d,
  input  logic [N-1:0] rd2_d,
  input  logic [N-1:0] imm_d,
  input  logic [N-1:0] pc_d,
  input  logic [N-1:0] pcplus4_d,
  input  logic [4:0]   rs1_d,
  input  logic [4:0]   rs2_d,
  input  logic [4:0]   rd_d,
  input  logic [2:0]   alu_control_d,
  input  logic         alusrc_d,
  input  logic         regwrite_d,
  input  logic         memwrite_d,
  input  logic         branch_d,
  input  logic         jump_d,
  input  logic [1:0]   resultsrc_d,
  input  logic [N-1:0] alu_result_m,
  input  logic [4:0]   rd_m,
  input  logic         regwrite_m,
  input  logic [N-1:0] result_w,
  input  logic [4:0]   rd_w,
  input  logic         regwrite_w,
  input  logic         pcsrc_e,
  output logic [N-1:0] src_a_e,
  output logic [N-1:0] src_b_e,
  output logic [2:0]   alu_control_e,
  output logic [N-1:0] write_data_e,
  output logic [N-1:0] imm_e,
  output logic [N-1:0] pc_e,
  output logic [N-1:0] pcplus4_e,
  output logic [4:0]   rd_e,
  output logic         regwrite_e,
  output logic         memwrite_e,
  output logic         branch_e,
  output logic         jump_e,
  output logic [1:0]   resultsrc_e,
  output logic         valid_e,
  output logic         stall_f,
  output logic         stall_d,
  output logic         flush_d
);

  typedef struct packed {
    logic [N-1:0] rd1;
    logic [N-1:0] rd2;
    logic [N-1:0] imm;
    logic [N-1:0] pc;
    logic [N-1:0] pcplus4;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic [2:0]   alu_control;
    logic         alusrc;
    logic         regwrite;
    logic         memwrite;
    logic         branch;
    logic         jump;
    logic [1:0]   resultsrc;
    logic         valid;
  } id_ex_t;

  localparam logic [1:0] RES_LOAD = 2'b01;

  id_ex_t ex_d;
  id_ex_t ex_q;

  logic         lw_stall;
  logic         bubble;
  logic         a_hit_m;
  logic         a_hit_w;
  logic         b_hit_m;
  logic         b_hit_w;
  logic [N-1:0] fwd_a;
  logic [N-1:0] fwd_b;

  // Load in EX whose destination is read by the decode instruction.
  always_comb begin
    lw_stall = ex_q.valid
             && (ex_q.resultsrc == RES_LOAD)
             && (ex_q.rd != 5'd0)
             && ((ex_q.rd == rs1_d) || (ex_q.rd == rs2_d));
  end

  assign stall_f = lw_stall;
  assign stall_d = lw_stall;
  assign flush_d = pcsrc_e;
  assign bubble  = lw_stall | pcsrc_e;

  always_comb begin
    ex_d = ex_q;
    if (bubble) begin
      ex_d = '0;
    end else begin
      ex_d.rd1         = rd1_d;
      ex_d.rd2         = rd2_d;
      ex_d.imm         = imm_d;
      ex_d.pc          = pc_d;
      ex_d.pcplus4     = pcplus4_d;
      ex_d.rs1         = rs1_d;
      ex_d.rs2         = rs2_d;
      ex_d.rd          = rd_d;
      ex_d.alu_control = alu_control_d;
      ex_d.alusrc      = alusrc_d;
      ex_d.regwrite    = regwrite_d;
      ex_d.memwrite    = memwrite_d;
      ex_d.branch      = branch_d;
      ex_d.jump        = jump_d;
      ex_d.resultsrc   = resultsrc_d;
      ex_d.valid       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // WB hits are masked by MEM hits so the case arms stay exclusive.
  always_comb begin
    a_hit_m = regwrite_m && (rd_m != 5'd0) && (rd_m == ex_q.rs1);
    a_hit_w = regwrite_w && (rd_w != 5'd0) && (rd_w == ex_q.rs1)
            && !a_hit_m;
    b_hit_m = regwrite_m && (rd_m != 5'd0) && (rd_m == ex_q.rs2);
    b_hit_w = regwrite_w && (rd_w != 5'd0) && (rd_w == ex_q.rs2)
            && !b_hit_m;
  end

  always_comb begin
    fwd_a = ex_q.rd1;
    unique case (1'b1)
      a_hit_m: fwd_a = alu_result_m;
      a_hit_w: fwd_a = result_w;
      default: fwd_a = ex_q.rd1;
    endcase
  end

  always_comb begin
    fwd_b = ex_q.rd2;
    unique case (1'b1)
      b_hit_m: fwd_b = alu_result_m;
      b_hit_w: fwd_b = result_w;
      default: fwd_b = ex_q.rd2;
    endcase
  end

  assign src_a_e      = fwd_a;
  assign src_b_e      = ex_q.alusrc ? ex_q.imm : fwd_b;
  assign write_data_e = fwd_b;

  assign alu_control_e = ex_q.alu_control;
  assign imm_e         = ex_q.imm;
  assign pc_e          = ex_q.pc;
  assign pcplus4_e     = ex_q.pcplus4;
  assign rd_e          = ex_q.rd;
  assign regwrite_e    = ex_q.regwrite;
  assign memwrite_e    = ex_q.memwrite;
  assign branch_e      = ex_q.branch;
  assign jump_e        = ex_q.jump;
  assign resultsrc_e   = ex_q.resultsrc;
  assign valid_e       = ex_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
// Hand-computed expectations for reset, forwarding and hazards.
module tb_id_ex_stage;

  localparam int N = 32;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] rd1_d, rd2_d, imm_d, pc_d, pcplus4_d;
  logic [4:0]   rs1_d, rs2_d, rd_d;
  logic [2:0]   alu_control_d;
  logic         alusrc_d, regwrite_d, memwrite_d, branch_d, jump_d;
  logic [1:0]   resultsrc_d;
  logic [N-1:0] alu_result_m, result_w;
  logic [4:0]   rd_m, rd_w;
  logic         regwrite_m, regwrite_w, pcsrc_e;
  logic [N-1:0] src_a_e, src_b_e, write_data_e;
  logic [N-1:0] imm_e, pc_e, pcplus4_e;
  logic [2:0]   alu_control_e;
  logic [4:0]   rd_e;
  logic         regwrite_e, memwrite_e, branch_e, jump_e, valid_e;
  logic [1:0]   resultsrc_e;
  logic         stall_f, stall_d, flush_d;

  int checks;
  int failures;

  id_ex_stage #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d),
    .pc_d(pc_d), .pcplus4_d(pcplus4_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .alu_control_d(alu_control_d), .alusrc_d(alusrc_d),
    .regwrite_d(regwrite_d), .memwrite_d(memwrite_d),
    .branch_d(branch_d), .jump_d(jump_d),
    .resultsrc_d(resultsrc_d),
    .alu_result_m(alu_result_m), .rd_m(rd_m),
    .regwrite_m(regwrite_m),
    .result_w(result_w), .rd_w(rd_w), .regwrite_w(regwrite_w),
    .pcsrc_e(pcsrc_e),
    .src_a_e(src_a_e), .src_b_e(src_b_e),
    .alu_control_e(alu_control_e), .write_data_e(write_data_e),
    .imm_e(imm_e), .pc_e(pc_e), .pcplus4_e(pcplus4_e),
    .rd_e(rd_e), .regwrite_e(regwrite_e),
    .memwrite_e(memwrite_e), .branch_e(branch_e),
    .jump_e(jump_e), .resultsrc_e(resultsrc_e),
    .valid_e(valid_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [N-1:0] got,
                     input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic decode(input logic [4:0] rs1,
                        input logic [N-1:0] v1,
                        input logic [4:0] rs2,
                        input logic [N-1:0] v2,
                        input logic [4:0] rd,
                        input logic [1:0] rsrc,
                        input logic asrc,
                        input logic [N-1:0] imm);
    rs1_d = rs1; rd1_d = v1;
    rs2_d = rs2; rd2_d = v2;
    rd_d = rd; resultsrc_d = rsrc;
    alusrc_d = asrc; imm_d = imm;
  endtask

  task automatic no_fwd();
    regwrite_m = 1'b0; rd_m = 5'd0; alu_result_m = '0;
    regwrite_w = 1'b0; rd_w = 5'd0; result_w = '0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    no_fwd();
    pcsrc_e = 1'b0;
    rst_n = 1'b0;
    decode(5'd3, 32'hAAAA_0001, 5'd4, 32'hBBBB_0002,
           5'd9, 2'b10, 1'b1, 32'h0000_1234);
    pc_d = 32'h0000_0100; pcplus4_d = 32'h0000_0104;
    alu_control_d = 3'b011;
    regwrite_d = 1'b1; memwrite_d = 1'b1;
    branch_d = 1'b1; jump_d = 1'b1;

    // Reset with nonzero inputs
    tick();
    chk("rst_valid", N'(valid_e), 0);
    chk("rst_rd", N'(rd_e), 0);
    chk("rst_aluc", N'(alu_control_e), 0);
    chk("rst_regwr", N'(regwrite_e), 0);
    chk("rst_memwr", N'(memwrite_e), 0);
    chk("rst_imm", imm_e, 0);
    chk("rst_pc", pc_e, 0);
    chk("rst_srca", src_a_e, 0);
    chk("rst_stall", N'(stall_f), 0);
    chk("rst_flush", N'(flush_d), 0);

    // First load after reset
    rst_n = 1'b1;
    decode(5'd5, 32'h0000_0033, 5'd0, 32'h0,
           5'd9, 2'b00, 1'b0, 32'h0000_0100);
    pc_d = 32'h0000_0080; pcplus4_d = 32'h0000_0084;
    alu_control_d = 3'b010;
    memwrite_d = 1'b0; branch_d = 1'b1; jump_d = 1'b0;
    tick();
    chk("ld_valid", N'(valid_e), 1);
    chk("ld_rd", N'(rd_e), 9);
    chk("ld_aluc", N'(alu_control_e), 3'b010);
    chk("ld_pc", pc_e, 32'h80);
    chk("ld_pc4", pcplus4_e, 32'h84);
    chk("ld_imm", imm_e, 32'h100);
    chk("ld_branch", N'(branch_e), 1);
    chk("ld_jump", N'(jump_e), 0);
    chk("ld_rsrc", N'(resultsrc_e), 0);
    chk("ld_srca", src_a_e, 32'h33);

    // Forward priority on A
    rd_m = 5'd5; regwrite_m = 1'b1; alu_result_m = 32'h11;
    rd_w = 5'd5; regwrite_w = 1'b1; result_w = 32'h22;
    settle();
    chk("fwd_a_mem", src_a_e, 32'h11);
    regwrite_m = 1'b0;
    settle();
    chk("fwd_a_wb", src_a_e, 32'h22);
    regwrite_w = 1'b0;
    settle();
    chk("fwd_a_reg", src_a_e, 32'h33);

    // x0 never forwarded
    rd_m = 5'd0; regwrite_m = 1'b1; alu_result_m = 32'hFF;
    rd_w = 5'd0; regwrite_w = 1'b1; result_w = 32'hEE;
    settle();
    chk("x0_srcb", src_b_e, 0);
    chk("x0_wdata", write_data_e, 0);
    chk("nold_stall", N'(stall_f), 0);
    no_fwd();

    // Load (rd=7) with immediate operand
    decode(5'd1, 32'h5, 5'd6, 32'h1,
           5'd7, 2'b01, 1'b1, 32'hFFFF_FFFC);
    tick();
    rd_m = 5'd6; regwrite_m = 1'b1; alu_result_m = 32'h40;
    settle();
    chk("imm_srcb", src_b_e, 32'hFFFF_FFFC);
    chk("imm_wdata", write_data_e, 32'h40);
    no_fwd();

    // Load-use on rs2
    decode(5'd3, 32'h0, 5'd7, 32'h0,
           5'd8, 2'b00, 1'b0, 32'h0);
    settle();
    chk("lu_stall_f", N'(stall_f), 1);
    chk("lu_stall_d", N'(stall_d), 1);
    chk("lu_flush_d", N'(flush_d), 0);
    tick();
    chk("lu_valid", N'(valid_e), 0);
    chk("lu_regwr", N'(regwrite_e), 0);
    chk("lu_rd", N'(rd_e), 0);
    chk("lu_release", N'(stall_f), 0);
    tick();
    chk("lu_reload", N'(valid_e), 1);
    chk("lu_reload_rd", N'(rd_e), 8);

    // Load to x0 never stalls
    decode(5'd1, 32'h0, 5'd2, 32'h0,
           5'd0, 2'b01, 1'b0, 32'h0);
    tick();
    decode(5'd0, 32'h0, 5'd0, 32'h0,
           5'd4, 2'b00, 1'b0, 32'h0);
    settle();
    chk("x0_load_stall", N'(stall_f), 0);

    // Load-use on rs1
    decode(5'd1, 32'h0, 5'd2, 32'h0,
           5'd10, 2'b01, 1'b0, 32'h0);
    tick();
    decode(5'd10, 32'h0, 5'd0, 32'h0,
           5'd4, 2'b00, 1'b0, 32'h0);
    settle();
    chk("lu_rs1_stall", N'(stall_d), 1);
    tick();
    chk("lu_rs1_valid", N'(valid_e), 0);

    // Branch flush
    tick();
    decode(5'd1, 32'h0, 5'd2, 32'h0,
           5'd12, 2'b00, 1'b0, 32'h0);
    regwrite_d = 1'b1;
    pcsrc_e = 1'b1;
    settle();
    chk("br_flush_d", N'(flush_d), 1);
    tick();
    chk("br_valid", N'(valid_e), 0);
    chk("br_regwr", N'(regwrite_e), 0);
    chk("br_rd", N'(rd_e), 0);
    pcsrc_e = 1'b0;
    settle();
    chk("br_flush_off", N'(flush_d), 0);

    // Reset mid-operation
    tick();
    chk("mid_valid", N'(valid_e), 1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", N'(valid_e), 0);
    chk("mid_rst_rd", N'(rd_e), 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", N'(valid_e), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
